multicast_fifo_buffer: RTL and testbench
========================================

Name: multicast_fifo_buffer

Overview:
Parametrised multi-reader FIFO for weight and input-data staging in the MAC datapath. One writer pushes words. NUM_READERS consumers each pop independently through their own head pointer. A slot is freed only once every reader has consumed it. This generalises the fixed two-reader, depth-4 buffer to arbitrary depth, width and reader count, and adds per-reader occupancy counts, an almost-full threshold and protected over/underflow handling.

Parameters:
DATA_WIDTH, 32, width of one data word
ADDR_WIDTH, 2, log2 of depth; DEPTH = 2**ADDR_WIDTH (depth is always a power of two)
NUM_READERS, 2, number of independent read ports (>=1)
AF_LEVEL, DEPTH-1, AlmostFull asserts when the slowest reader's count >= AF_LEVEL

Ports:
clk  input  1  rising-edge clock
aclr  input  1  reset, synchronous, active-high
Push  input  1  write request
DataIn  input  DATA_WIDTH  write data
Pop  input  NUM_READERS  per-reader pop request, bit r = reader r
DataOut  output  NUM_READERS*DATA_WIDTH  show-ahead head word of each reader; slice r = reader r
Empty  output  NUM_READERS  bit r high when reader r has no unread words
Full  output  1  no free slot for any reader
AlmostFull  output  1  max count >= AF_LEVEL
Count  output  NUM_READERS*(ADDR_WIDTH+1)  unread words per reader, 0..DEPTH
Occupied  output  DEPTH  bit i high when slot i is unread by at least one reader

Behaviour:
- One clock domain. Reset is synchronous and active-high on aclr, sampled at the clk rising edge.
- State held in registers:
  - write pointer wp, ADDR_WIDTH+1 bits (extra wrap bit)
  - one read pointer rp[r] per reader, ADDR_WIDTH+1 bits
  - storage array mem[DEPTH]
- Reset:
  - wp and all rp[r] are cleared to 0; mem is not cleared.
  - Outputs after reset: Empty = all ones, Full = 0, AlmostFull = 0 (AlmostFull = 1 only if AF_LEVEL = 0), Count = 0, Occupied = 0.
  - DataOut is don't-care while Empty[r] = 1.
  - Push and Pop are ignored in any cycle where aclr = 1, including mid-stream. All data is discarded.
- Count[r] = wp - rp[r], modulo 2**(ADDR_WIDTH+1).
- Empty[r] = (Count[r] == 0).
- Full = (max over r of Count[r]) == DEPTH.
- All flags and counts are combinational from registered pointers only; they never depend on same-cycle Push or Pop.
- Occupied[i] is the OR over readers of "slot i lies in [rp[r], wp)", computed with the wrap bit.
- Write:
  - When Push = 1 and Full = 0: mem[wp[ADDR_WIDTH-1:0]] <= DataIn and wp <= wp+1.
  - When Push = 1 and Full = 1: the push is dropped and no state changes.
- Read:
  - DataOut slice r = mem[rp[r][ADDR_WIDTH-1:0]]. It is combinational (show-ahead) and valid whenever Empty[r] = 0.
  - When Pop[r] = 1 and Empty[r] = 0: rp[r] <= rp[r]+1.
  - When Pop[r] = 1 and Empty[r] = 1: the pop is dropped and rp[r] is unchanged.
- Simultaneous events:
  - Push on an empty reader: the pop for that reader is dropped. The new word appears on DataOut the next cycle (1-cycle write-to-read latency).
  - Push while Full, even with a same-cycle pop by the slowest reader: the push is dropped. Full uses the start-of-cycle state, so there is no write-through.
  - Push and pop in the same non-full, non-empty cycle: both take effect and Count[r] is unchanged.
  - Several readers popping in one cycle is legal; pointers move independently.
- Wrap-around: pointers wrap modulo 2**(ADDR_WIDTH+1). The wrap bit distinguishes full (Count = DEPTH) from empty (Count = 0).

Optional Feature:
Macro MCFIFO_ERR_FLAGS_EN.
- Defined: adds three ports.
  - ClrErr, input, 1: clears both flags.
  - Overflow, output, 1: set on a cycle where Push = 1 and Full = 1.
  - Underflow, output, NUM_READERS: bit r set on a cycle where Pop[r] = 1 and Empty[r] = 1.
  - Both flags are registered and sticky. They are cleared by aclr or by ClrErr = 1; a set condition in the same cycle as ClrErr wins.
  - Flags become visible the cycle after the error.
- Undefined: these ports and registers are absent. Dropped pushes and pops are silent. Core behaviour is identical.

Test Plan:
- Reset then idle, NUM_READERS = 2, ADDR_WIDTH = 2 -> Empty = 2'b11, Full = 0, Count = 0, Occupied = 4'b0000.
- Push 0xA0..0xA3 on 4 consecutive cycles, no pops -> Full = 1, Occupied = 4'hF, Count = {4,4}, AlmostFull = 1 from the 3rd word. A 5th Push of 0xA4 is dropped; with MCFIFO_ERR_FLAGS_EN, Overflow = 1 the next cycle.
- From full, reader 0 pops 4 times, reader 1 idle -> DataOut0 shows A0, A1, A2, A3 in order, Empty = 2'b01, Full stays 1, Occupied stays 4'hF. Then reader 1 pops once -> Full = 0, Occupied = 4'b1110.
- Wrap-around: 10 pushes interleaved with pops of both readers, keeping Count <= 2 -> both readers see the exact push order and pointers wrap through 0.
- Push 0x55 with Pop = 2'b11 on an empty FIFO -> pops dropped, Underflow = 2'b11 (if enabled), DataOut0 = DataOut1 = 0x55 the next cycle, Count = {1,1}.
- aclr asserted with 3 words held and Push = 1 in the same cycle -> next cycle Empty = 2'b11, Count = 0, Occupied = 0. Push data is not stored.

Source files
------------

// File: rtl/multicast_fifo_buffer.sv
// Multi-reader FIFO: one writer, NUM_READERS independent show-ahead readers; a slot is freed once all readers consumed it.
// Optional sticky Overflow/Underflow error flags with ClrErr are compiled in when MCFIFO_ERR_FLAGS_EN is defined.
module multicast_fifo_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 2,
    parameter int NUM_READERS = 2,
    parameter int AF_LEVEL    = (2 ** ADDR_WIDTH) - 1
) (
    input  logic                                 clk,
    input  logic                                 aclr,
    input  logic                                 Push,
    input  logic [DATA_WIDTH-1:0]                DataIn,
    input  logic [NUM_READERS-1:0]               Pop,
`ifdef MCFIFO_ERR_FLAGS_EN
    input  logic                                 ClrErr,
    output logic                                 Overflow,
    output logic [NUM_READERS-1:0]               Underflow,
`endif
    output logic [NUM_READERS*DATA_WIDTH-1:0]    DataOut,
    output logic [NUM_READERS-1:0]               Empty,
    output logic                                 Full,
    output logic                                 AlmostFull,
    output logic [NUM_READERS*(ADDR_WIDTH+1)-1:0] Count,
    output logic [(2**ADDR_WIDTH)-1:0]           Occupied
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);

    logic [PW-1:0]         wp_q, wp_d;
    logic [PW-1:0]         rp_q [NUM_READERS];
    logic [PW-1:0]         rp_d [NUM_READERS];
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]          cnt [NUM_READERS];
    logic [PW-1:0]          max_cnt;
    logic [NUM_READERS-1:0] empty;
    logic                   full;
    logic                   wr_en;
    logic [NUM_READERS-1:0] rd_en;
    logic [ADDR_WIDTH-1:0]  slot_off;
    logic [DEPTH-1:0]       occ;

    // Flags come from registered pointers only, never from same-cycle requests.
    always_comb begin
        max_cnt = '0;
        empty   = '0;
        for (int r = 0; r < NUM_READERS; r++) begin
            cnt[r]   = wp_q - rp_q[r];
            empty[r] = (cnt[r] == '0);
            if (cnt[r] > max_cnt) begin
                max_cnt = cnt[r];
            end
        end
        full = (max_cnt == DEPTH_C);
    end

    assign wr_en = Push & ~full;
    assign rd_en = Pop & ~empty;

    always_comb begin
        wp_d = wr_en ? wp_q + PW'(1) : wp_q;
        for (int r = 0; r < NUM_READERS; r++) begin
            rp_d[r] = rd_en[r] ? rp_q[r] + PW'(1) : rp_q[r];
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            wp_q <= '0;
            for (int r = 0; r < NUM_READERS; r++) begin
                rp_q[r] <= '0;
            end
        end else begin
            wp_q <= wp_d;
            for (int r = 0; r < NUM_READERS; r++) begin
                rp_q[r] <= rp_d[r];
            end
        end
    end

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !aclr) begin
            mem_q[wp_q[ADDR_WIDTH-1:0]] <= DataIn;
        end
    end

    // Slot i is live for reader r when its distance ahead of rp[r] is below that reader's count.
    always_comb begin
        occ      = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int r = 0; r < NUM_READERS; r++) begin
                slot_off = ADDR_WIDTH'(i) - rp_q[r][ADDR_WIDTH-1:0];
                if ({1'b0, slot_off} < cnt[r]) begin
                    occ[i] = 1'b1;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_READERS; g++) begin : g_rd
            assign DataOut[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[rp_q[g][ADDR_WIDTH-1:0]];
            assign Count[g*PW +: PW]                   = cnt[g];
        end
    endgenerate

    assign Empty      = empty;
    assign Full       = full;
    assign AlmostFull = (max_cnt >= AF_C);
    assign Occupied   = occ;

`ifdef MCFIFO_ERR_FLAGS_EN
    logic                   ovf_q, ovf_d;
    logic [NUM_READERS-1:0] udf_q, udf_d;

    // A new error in the same cycle as ClrErr keeps the flag set.
    always_comb begin
        ovf_d = ClrErr ? 1'b0 : ovf_q;
        if (Push && full) begin
            ovf_d = 1'b1;
        end
        udf_d = (ClrErr ? '0 : udf_q) | (Pop & empty);
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            ovf_q <= 1'b0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign Overflow  = ovf_q;
    assign Underflow = udf_q;
`endif

endmodule

// File: tb/tb_multicast_fifo_buffer.sv
// Bench for multicast_fifo_buffer: hand-built vector table, then a queue-based reference model driving a scoreboard.
module tb_multicast_fifo_buffer;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int NR    = 2;
    localparam int DEPTH = 4;
    localparam int PW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              aclr;
    logic              Push;
    logic [DW-1:0]     DataIn;
    logic [NR-1:0]     Pop;
    logic [NR*DW-1:0]  DataOut;
    logic [NR-1:0]     Empty;
    logic              Full;
    logic              AlmostFull;
    logic [NR*PW-1:0]  Count;
    logic [DEPTH-1:0]  Occupied;
`ifdef MCFIFO_ERR_FLAGS_EN
    logic              ClrErr;
    logic              Overflow;
    logic [NR-1:0]     Underflow;
`endif

    multicast_fifo_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READERS(NR), .AF_LEVEL(DEPTH - 1)
    ) dut (
        .clk(clk), .aclr(aclr), .Push(Push), .DataIn(DataIn), .Pop(Pop),
`ifdef MCFIFO_ERR_FLAGS_EN
        .ClrErr(ClrErr), .Overflow(Overflow), .Underflow(Underflow),
`endif
        .DataOut(DataOut), .Empty(Empty), .Full(Full), .AlmostFull(AlmostFull),
        .Count(Count), .Occupied(Occupied)
    );

    typedef struct {
        logic [1:0]  empty;
        logic        full;
        logic        af;
        logic [5:0]  count;
        logic [3:0]  occ;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        ovf;
        logic [1:0]  udf;
    } exp_t;

    typedef struct {
        logic        a;
        logic        p;
        logic [31:0] din;
        logic [1:0]  pop;
        logic        clr;
        exp_t        e;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    logic clr_unused;
    exp_t sb[$];
    vec_t tbl[26];

    // Reference model: one queue of unread words (and their slot numbers) per reader.
    logic [31:0] mq_d [NR][$];
    int          mq_s [NR][$];
    int          wslot;
    logic        m_ovf;
    logic [1:0]  m_udf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a, input logic p, input logic [31:0] din,
                                input logic [1:0] pop, input logic clr, input logic [1:0] em,
                                input logic fu, input logic af, input int c1, input int c0,
                                input logic [3:0] occ, input logic [31:0] d0, input logic [31:0] d1,
                                input logic ovf, input logic [1:0] udf);
        vec_t v;
        v.a = a; v.p = p; v.din = din; v.pop = pop; v.clr = clr;
        v.e.empty = em; v.e.full = fu; v.e.af = af;
        v.e.count = {3'(c1), 3'(c0)};
        v.e.occ = occ; v.e.d0 = d0; v.e.d1 = d1; v.e.ovf = ovf; v.e.udf = udf;
        return v;
    endfunction

    task automatic drive_check(input logic a, input logic p, input logic [31:0] din,
                               input logic [1:0] pop, input logic clr, input exp_t e,
                               input string tag);
        exp_t x;
        aclr = a; Push = p; DataIn = din; Pop = pop;
`ifdef MCFIFO_ERR_FLAGS_EN
        ClrErr = clr;
`else
        clr_unused = clr;
`endif
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        x = sb.pop_front();
        chk({tag, ".Empty"}, 64'(Empty), 64'(x.empty));
        chk({tag, ".Full"}, 64'(Full), 64'(x.full));
        chk({tag, ".AlmostFull"}, 64'(AlmostFull), 64'(x.af));
        chk({tag, ".Count"}, 64'(Count), 64'(x.count));
        chk({tag, ".Occupied"}, 64'(Occupied), 64'(x.occ));
        if (!x.empty[0]) chk({tag, ".DataOut0"}, 64'(DataOut[31:0]), 64'(x.d0));
        if (!x.empty[1]) chk({tag, ".DataOut1"}, 64'(DataOut[63:32]), 64'(x.d1));
`ifdef MCFIFO_ERR_FLAGS_EN
        chk({tag, ".Overflow"}, 64'(Overflow), 64'(x.ovf));
        chk({tag, ".Underflow"}, 64'(Underflow), 64'(x.udf));
`endif
    endtask

    task automatic model_step(input logic a, input logic p, input logic [31:0] din,
                              input logic [1:0] pop, input logic clr, input string tag);
        exp_t       e;
        logic       mfull;
        logic [1:0] memp;
        int         mx;
        mfull = 1'b0;
        for (int r = 0; r < NR; r++) begin
            memp[r] = (mq_d[r].size() == 0);
            if (mq_d[r].size() == DEPTH) mfull = 1'b1;
        end
        if (a) begin
            for (int r = 0; r < NR; r++) begin
                mq_d[r].delete();
                mq_s[r].delete();
            end
            wslot = 0; m_ovf = 1'b0; m_udf = '0;
        end else begin
            if (clr) begin
                m_ovf = 1'b0; m_udf = '0;
            end
            if (p && mfull) m_ovf = 1'b1;
            m_udf = m_udf | (pop & memp);
            for (int r = 0; r < NR; r++) begin
                if (pop[r] && !memp[r]) begin
                    void'(mq_d[r].pop_front());
                    void'(mq_s[r].pop_front());
                end
            end
            if (p && !mfull) begin
                for (int r = 0; r < NR; r++) begin
                    mq_d[r].push_back(din);
                    mq_s[r].push_back(wslot);
                end
                wslot = (wslot + 1) % DEPTH;
            end
        end
        mx = 0; e.occ = '0; e.d0 = '0; e.d1 = '0;
        for (int r = 0; r < NR; r++) begin
            e.empty[r] = (mq_d[r].size() == 0);
            e.count[r*PW +: PW] = 3'(mq_d[r].size());
            if (mq_d[r].size() > mx) mx = mq_d[r].size();
            foreach (mq_s[r][k]) e.occ[mq_s[r][k]] = 1'b1;
        end
        if (mq_d[0].size() > 0) e.d0 = mq_d[0][0];
        if (mq_d[1].size() > 0) e.d1 = mq_d[1][0];
        e.full = (mx == DEPTH);
        e.af   = (mx >= DEPTH - 1);
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        drive_check(a, p, din, pop, clr, e, tag);
    endtask

    initial begin
        //               a  p  din    pop  clr em   fu af c1 c0 occ      d0     d1     ovf udf
        tbl[0]  = mk(1, 0, 32'h00, 2'b00, 0, 2'b11, 0, 0, 0, 0, 4'b0000, 32'h00, 32'h00, 0, 2'b00);
        tbl[1]  = mk(0, 0, 32'h00, 2'b00, 0, 2'b11, 0, 0, 0, 0, 4'b0000, 32'h00, 32'h00, 0, 2'b00);
        tbl[2]  = mk(0, 1, 32'hA0, 2'b00, 0, 2'b00, 0, 0, 1, 1, 4'b0001, 32'hA0, 32'hA0, 0, 2'b00);
        tbl[3]  = mk(0, 1, 32'hA1, 2'b00, 0, 2'b00, 0, 0, 2, 2, 4'b0011, 32'hA0, 32'hA0, 0, 2'b00);
        tbl[4]  = mk(0, 1, 32'hA2, 2'b00, 0, 2'b00, 0, 1, 3, 3, 4'b0111, 32'hA0, 32'hA0, 0, 2'b00);
        tbl[5]  = mk(0, 1, 32'hA3, 2'b00, 0, 2'b00, 1, 1, 4, 4, 4'b1111, 32'hA0, 32'hA0, 0, 2'b00);
        tbl[6]  = mk(0, 1, 32'hA4, 2'b00, 0, 2'b00, 1, 1, 4, 4, 4'b1111, 32'hA0, 32'hA0, 1, 2'b00);
        tbl[7]  = mk(0, 0, 32'h00, 2'b01, 0, 2'b00, 1, 1, 4, 3, 4'b1111, 32'hA1, 32'hA0, 1, 2'b00);
        tbl[8]  = mk(0, 0, 32'h00, 2'b01, 0, 2'b00, 1, 1, 4, 2, 4'b1111, 32'hA2, 32'hA0, 1, 2'b00);
        tbl[9]  = mk(0, 0, 32'h00, 2'b01, 0, 2'b00, 1, 1, 4, 1, 4'b1111, 32'hA3, 32'hA0, 1, 2'b00);
        tbl[10] = mk(0, 0, 32'h00, 2'b01, 0, 2'b01, 1, 1, 4, 0, 4'b1111, 32'h00, 32'hA0, 1, 2'b00);
        tbl[11] = mk(0, 0, 32'h00, 2'b01, 0, 2'b01, 1, 1, 4, 0, 4'b1111, 32'h00, 32'hA0, 1, 2'b01);
        tbl[12] = mk(0, 0, 32'h00, 2'b10, 0, 2'b01, 0, 1, 3, 0, 4'b1110, 32'h00, 32'hA1, 1, 2'b01);
        tbl[13] = mk(0, 0, 32'h00, 2'b10, 1, 2'b01, 0, 0, 2, 0, 4'b1100, 32'h00, 32'hA2, 0, 2'b00);
        tbl[14] = mk(0, 0, 32'h00, 2'b10, 0, 2'b01, 0, 0, 1, 0, 4'b1000, 32'h00, 32'hA3, 0, 2'b00);
        tbl[15] = mk(0, 0, 32'h00, 2'b10, 0, 2'b11, 0, 0, 0, 0, 4'b0000, 32'h00, 32'h00, 0, 2'b00);
        tbl[16] = mk(0, 1, 32'h55, 2'b11, 0, 2'b00, 0, 0, 1, 1, 4'b0001, 32'h55, 32'h55, 0, 2'b11);
        tbl[17] = mk(0, 1, 32'h66, 2'b11, 1, 2'b00, 0, 0, 1, 1, 4'b0010, 32'h66, 32'h66, 0, 2'b00);
        tbl[18] = mk(0, 1, 32'h77, 2'b00, 0, 2'b00, 0, 0, 2, 2, 4'b0110, 32'h66, 32'h66, 0, 2'b00);
        tbl[19] = mk(0, 1, 32'h88, 2'b00, 0, 2'b00, 0, 1, 3, 3, 4'b1110, 32'h66, 32'h66, 0, 2'b00);
        tbl[20] = mk(1, 1, 32'h99, 2'b11, 0, 2'b11, 0, 0, 0, 0, 4'b0000, 32'h00, 32'h00, 0, 2'b00);
        tbl[21] = mk(0, 0, 32'h00, 2'b00, 0, 2'b11, 0, 0, 0, 0, 4'b0000, 32'h00, 32'h00, 0, 2'b00);
        tbl[22] = mk(0, 1, 32'h11, 2'b00, 0, 2'b00, 0, 0, 1, 1, 4'b0001, 32'h11, 32'h11, 0, 2'b00);
        tbl[23] = mk(0, 0, 32'h00, 2'b11, 0, 2'b11, 0, 0, 0, 0, 4'b0000, 32'h00, 32'h00, 0, 2'b00);
        tbl[24] = mk(0, 0, 32'h00, 2'b11, 1, 2'b11, 0, 0, 0, 0, 4'b0000, 32'h00, 32'h00, 0, 2'b11);
        tbl[25] = mk(0, 0, 32'h00, 2'b00, 1, 2'b11, 0, 0, 0, 0, 4'b0000, 32'h00, 32'h00, 0, 2'b00);

        for (int i = 0; i < 26; i++) begin
            drive_check(tbl[i].a, tbl[i].p, tbl[i].din, tbl[i].pop, tbl[i].clr, tbl[i].e,
                        $sformatf("vec%0d", i));
        end

        // Model-driven sequences start from a fresh reset.
        model_step(1, 0, 0, 2'b00, 0, "rst");
        for (int i = 0; i < 10; i++) begin
            model_step(0, 1, 32'hC0 + 32'(i), (i > 0) ? 2'b11 : 2'b00, 0, $sformatf("wrap%0d", i));
        end
        model_step(0, 0, 0, 2'b11, 0, "wrap_drain");

        // Full, slowest reader pops while a push arrives: the push must still be dropped.
        for (int i = 0; i < 4; i++) begin
            model_step(0, 1, 32'hD0 + 32'(i), 2'b00, 0, $sformatf("fill%0d", i));
        end
        model_step(0, 1, 32'hDD, 2'b11, 0, "full_push_pop");
        model_step(0, 0, 0, 2'b00, 0, "full_after");

        for (int i = 0; i < 400; i++) begin
            model_step($urandom_range(0, 49) == 0, 1'($urandom),
                       $urandom, 2'($urandom), $urandom_range(0, 19) == 0,
                       $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
